// File: rtl/ise_param.sv
// ise_param: classifies each image's pixels by dominant colour, averages the winning class,
// keeps a sorted list of {class, average, id} and streams it out once all images are in.
module ise_param #(
  parameter int NUM_IMG = 32,
  parameter int LOG_PIX = 14,
  parameter int PIX_W = 8,
  parameter int FRAC_W = 8,
  parameter int DESC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pixel_valid,
  input  logic [$clog2(NUM_IMG)-1:0] image_in_index,
  input  logic [3*PIX_W-1:0]         pixel_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 color_index,
  output logic [$clog2(NUM_IMG)-1:0] image_out_index,
  output logic                       done
);
  localparam int IDX_W = $clog2(NUM_IMG);
  localparam int AVG_W = PIX_W + FRAC_W;
  localparam int SW = PIX_W + LOG_PIX;
  localparam int CW = LOG_PIX + 1;
  localparam int STW = $clog2(AVG_W + 1);

  typedef enum logic [2:0] {S_IN, S_DIV, S_INSERT, S_OUT, S_DONE} state_t;

  state_t state;
  logic [SW-1:0] sum [3];
  logic [CW-1:0] cnt [3];
  logic [LOG_PIX-1:0] pix;
  logic [IDX_W-1:0] id_r, ptr;
  logic [1:0] cls_r, cls_in, dom;
  logic [CW-1:0] rem, dvs, sel_cnt;
  logic [CW:0] trial, diff;
  logic [AVG_W-1:0] dq;
  logic [STW-1:0] st;
  logic [SW-1:0] sel_sum;
  logic [PIX_W-1:0] r, g, b, comp;
  logic [2:0] hit;
  logic accept, ge;
  logic [1:0] cls_l [NUM_IMG];
  logic [AVG_W-1:0] avg_l [NUM_IMG];
  logic [IDX_W-1:0] id_l [NUM_IMG];
  logic [1:0] cls_p [NUM_IMG];
  logic [AVG_W-1:0] avg_p [NUM_IMG];
  logic [IDX_W-1:0] id_p [NUM_IMG];
  logic [NUM_IMG-1:0] vld, keep, at;

  assign busy = state != S_IN;
  assign out_valid = state == S_OUT;
  assign done = state == S_DONE;
  assign color_index = cls_l[ptr];
  assign image_out_index = id_l[ptr];

  always_comb begin
    {r, g, b} = pixel_in;
    accept = pixel_valid && !busy;
    cls_in = (r >= g && r >= b) ? 2'd0 : (g >= b && g > r) ? 2'd1 : 2'd2;
    comp = cls_in == 2'd0 ? r : cls_in == 2'd1 ? g : b;
    hit = accept ? 3'b001 << cls_in : 3'b000;
    dom = (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) ? 2'd0 : (cnt[1] >= cnt[2]) ? 2'd1 : 2'd2;
    sel_sum = dom == 2'd0 ? sum[0] : dom == 2'd1 ? sum[1] : sum[2];
    sel_cnt = dom == 2'd0 ? cnt[0] : dom == 2'd1 ? cnt[1] : cnt[2];
    trial = {rem, dq[AVG_W-1]};
    ge = trial >= {1'b0, dvs};
    diff = trial - {1'b0, dvs};
    // keep marks the sorted prefix that stays put; equal keys stay ahead of the newcomer
    for (int i = 0; i < NUM_IMG; i++)
      keep[i] = vld[i] && (cls_l[i] < cls_r ||
                (cls_l[i] == cls_r && (DESC != 0 ? avg_l[i] >= dq : avg_l[i] <= dq)));
    at = ~keep & {keep[NUM_IMG-2:0], 1'b1};
    for (int i = 0; i < NUM_IMG; i++) begin
      cls_p[i] = cls_r;
      avg_p[i] = dq;
      id_p[i] = id_r;
    end
    for (int i = 1; i < NUM_IMG; i++) begin
      cls_p[i] = at[i] ? cls_r : cls_l[i-1];
      avg_p[i] = at[i] ? dq : avg_l[i-1];
      id_p[i] = at[i] ? id_r : id_l[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IN;
      pix <= '0;
      id_r <= '0;
      ptr <= '0;
      cls_r <= '0;
      rem <= '0;
      dvs <= '0;
      dq <= '0;
      st <= '0;
      vld <= '0;
      for (int k = 0; k < 3; k++) begin
        sum[k] <= '0;
        cnt[k] <= '0;
      end
      for (int i = 0; i < NUM_IMG; i++) begin
        cls_l[i] <= '0;
        avg_l[i] <= '0;
        id_l[i] <= '0;
      end
    end else begin
      case (state)
        S_IN: if (accept) begin
          pix <= pix + 1'b1;
          if (pix == '0) id_r <= image_in_index;
          for (int k = 0; k < 3; k++)
            if (hit[k]) begin
              sum[k] <= sum[k] + SW'(comp);
              cnt[k] <= cnt[k] + 1'b1;
            end
          if (&pix) state <= S_DIV;
        end
        S_DIV: begin
          st <= st + 1'b1;
          // average fits AVG_W bits, so the bits above them seed the remainder below the divisor
          if (st == '0) begin
            cls_r <= dom;
            dvs <= sel_cnt;
            rem <= {1'b0, sel_sum[SW-1:PIX_W]};
            dq <= {sel_sum[PIX_W-1:0], {FRAC_W{1'b0}}};
          end else begin
            rem <= ge ? diff[CW-1:0] : trial[CW-1:0];
            dq <= {dq[AVG_W-2:0], ge};
          end
          if (st == STW'(AVG_W)) begin
            st <= '0;
            state <= S_INSERT;
          end
        end
        S_INSERT: begin
          for (int i = 0; i < NUM_IMG; i++)
            if (!keep[i]) begin
              cls_l[i] <= cls_p[i];
              avg_l[i] <= avg_p[i];
              id_l[i] <= id_p[i];
            end
          for (int k = 0; k < 3; k++) begin
            sum[k] <= '0;
            cnt[k] <= '0;
          end
          vld <= vld | {vld[NUM_IMG-2:0], 1'b1};
          state <= vld[NUM_IMG-2] ? S_OUT : S_IN;
        end
        S_OUT: if (out_ready) begin
          if (ptr == IDX_W'(NUM_IMG - 1)) state <= S_DONE;
          else ptr <= ptr + 1'b1;
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IN;
      endcase
    end
  end
endmodule

// File: tb/tb_ise_param.sv
// tb_ise_param: directed-vector bench for ise_param (small, DESC and default configurations)
module tb_ise_param;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst_n, pv, ordy;
  logic [1:0] idx;
  logic [23:0] pix;
  logic busy0, ov0, done0, busy1, ov1, done1;
  logic [1:0] ci0, io0, ci1, io1;

  logic rst2, pv2, idx2, ordy2, busy2, ov2, done2, io2;
  logic [23:0] pix2;
  logic [1:0] ci2;

  logic rst3, pv3, ordy3, busy3, ov3, done3;
  logic [4:0] idx3, io3;
  logic [23:0] pix3;
  logic [1:0] ci3;

  ise_param #(.NUM_IMG(4), .LOG_PIX(2), .DESC(0)) u0 (
    .clk(clk), .reset(rst_n), .pixel_valid(pv), .image_in_index(idx), .pixel_in(pix),
    .busy(busy0), .out_valid(ov0), .out_ready(ordy), .color_index(ci0),
    .image_out_index(io0), .done(done0));
  ise_param #(.NUM_IMG(4), .LOG_PIX(2), .DESC(1)) u1 (
    .clk(clk), .reset(rst_n), .pixel_valid(pv), .image_in_index(idx), .pixel_in(pix),
    .busy(busy1), .out_valid(ov1), .out_ready(ordy), .color_index(ci1),
    .image_out_index(io1), .done(done1));
  ise_param #(.NUM_IMG(2), .LOG_PIX(3)) u2 (
    .clk(clk), .reset(rst2), .pixel_valid(pv2), .image_in_index(idx2), .pixel_in(pix2),
    .busy(busy2), .out_valid(ov2), .out_ready(ordy2), .color_index(ci2),
    .image_out_index(io2), .done(done2));
  ise_param u3 (
    .clk(clk), .reset(rst3), .pixel_valid(pv3), .image_in_index(idx3), .pixel_in(pix3),
    .busy(busy3), .out_valid(ov3), .out_ready(ordy3), .color_index(ci3),
    .image_out_index(io3), .done(done3));

  typedef struct packed {
    logic [15:0][23:0] px;
    logic [3:0][3:0] e0;
    logic [3:0][3:0] e1;
  } vec_t;

  vec_t vec [6];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rgb(input int r, input int g, input int b);
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic logic [15:0][23:0] uni(input logic [23:0] a, b, c, d);
    logic [15:0][23:0] v;
    for (int p = 0; p < 4; p++) begin
      v[p] = a;
      v[4+p] = b;
      v[8+p] = c;
      v[12+p] = d;
    end
    return v;
  endfunction

  // entry nibble = {class, id}; element 0 is the first entry out
  function automatic logic [3:0][3:0] ex(input logic [3:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; pv = 0; ordy = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // mode 0: plain drain, 1: stall 5 cycles after 2nd entry, 2: reset after 1st entry
  task automatic run(input int v, input int mode, input bit rst);
    int n, k, stall;
    if (rst) do_reset();
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 4; p++) begin
        @(negedge clk);
        pv = 1; idx = m[1:0]; pix = vec[v].px[m*4+p];
      end
      @(negedge clk);
      pv = 0;
      n = 0;
      while ((m < 3 ? busy0 : !ov0) && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d img%0d settle timeout", v, m), n < 40, 1);
    end
    k = 0; stall = 0; n = 0;
    while (k < 4 && n < 60) begin
      chk($sformatf("v%0d e%0d out_valid", v, k), ov0, 1);
      chk($sformatf("v%0d e%0d asc entry", v, k), {ci0, io0}, vec[v].e0[k]);
      chk($sformatf("v%0d e%0d desc entry", v, k), {ci1, io1}, vec[v].e1[k]);
      if (mode == 2 && k == 1) begin
        rst_n = 0;
        #1;
        chk("midout rst busy", busy0, 0);
        chk("midout rst out_valid", ov0, 0);
        chk("midout rst done", done0, 0);
        chk("midout rst outputs", {ci0, io0}, 0);
        @(negedge clk);
        rst_n = 1; ordy = 0;
        return;
      end
      ordy = !(mode == 1 && k == 2 && stall < 5);
      if (ordy) k++;
      else stall++;
      @(negedge clk);
      n++;
    end
    ordy = 0;
    chk($sformatf("v%0d entry count", v), k, 4);
    if (mode == 1) chk("stall cycles", stall, 5);
    chk($sformatf("v%0d done", v), done0, 1);
    chk($sformatf("v%0d done desc", v), done1, 1);
    chk($sformatf("v%0d out_valid low", v), ov0, 0);
    chk($sformatf("v%0d busy in done", v), busy0, 1);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d done held", v), done0, 1);
  endtask

  initial begin
    int n, m;
    rst_n = 0; pv = 0; ordy = 0; idx = 0; pix = 0;
    rst2 = 0; pv2 = 0; ordy2 = 0; idx2 = 0; pix2 = 0;
    rst3 = 0; pv3 = 0; ordy3 = 0; idx3 = 0; pix3 = 0;

    vec[0].px = uni(rgb(0, 40, 0), rgb(80, 0, 0), rgb(20, 0, 0), rgb(0, 0, 60));
    vec[0].e0 = ex(4'h2, 4'h1, 4'h4, 4'hB);
    vec[0].e1 = ex(4'h1, 4'h2, 4'h4, 4'hB);
    vec[1].px = uni(rgb(50, 0, 0), rgb(50, 0, 0), rgb(0, 10, 0), rgb(0, 0, 30));
    vec[1].e0 = ex(4'h0, 4'h1, 4'h6, 4'hB);
    vec[1].e1 = ex(4'h0, 4'h1, 4'h6, 4'hB);
    vec[2].px = uni(rgb(20, 0, 0), rgb(80, 0, 0), rgb(0, 0, 100), rgb(0, 0, 5));
    vec[2].e0 = ex(4'h0, 4'h1, 4'hB, 4'hA);
    vec[2].e1 = ex(4'h1, 4'h0, 4'hA, 4'hB);
    vec[3].px = uni(rgb(0, 200, 0), rgb(0, 100, 0), rgb(0, 150, 0), rgb(0, 1, 0));
    vec[3].e0 = ex(4'h7, 4'h5, 4'h6, 4'h4);
    vec[3].e1 = ex(4'h4, 4'h6, 4'h5, 4'h7);
    vec[4].px = uni(rgb(100, 0, 0), rgb(101, 0, 0), rgb(99, 0, 0), rgb(5, 9, 9));
    vec[4].px[3] = rgb(0, 0, 200);
    vec[4].px[15] = rgb(10, 10, 10);
    vec[4].e0 = ex(4'h2, 4'h0, 4'h1, 4'h7);
    vec[4].e1 = ex(4'h1, 4'h0, 4'h2, 4'h7);
    vec[5].px = uni(rgb(10, 10, 10), rgb(0, 0, 7), rgb(3, 3, 0), rgb(0, 8, 8));
    vec[5].px[2] = rgb(0, 50, 0);
    vec[5].px[3] = rgb(0, 50, 0);
    vec[5].e0 = ex(4'h2, 4'h0, 4'h7, 4'h9);
    vec[5].e1 = ex(4'h0, 4'h2, 4'h7, 4'h9);

    #1;
    chk("reset busy", busy0, 0);
    chk("reset out_valid", ov0, 0);
    chk("reset done", done0, 0);
    chk("reset outputs", {ci0, io0}, 0);

    // reset in the middle of the division, then a fresh run without another reset
    @(negedge clk);
    rst_n = 1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      pv = 1; idx = 2'd3; pix = rgb(0, 0, 90);
    end
    @(negedge clk);
    pv = 0;
    repeat (4) @(negedge clk);
    chk("busy in div", busy0, 1);
    rst_n = 0;
    #1;
    chk("middiv rst busy", busy0, 0);
    chk("middiv rst out_valid", ov0, 0);
    chk("middiv rst done", done0, 0);
    chk("middiv rst outputs", {ci0, io0}, 0);
    @(negedge clk);
    rst_n = 1;
    run(0, 0, 0);

    for (int v = 1; v < 6; v++) run(v, 0, 1);
    run(0, 1, 1);
    run(2, 2, 1);
    run(3, 0, 1);

    // busy window at default widths, ignored pixels during busy and pixel_valid gaps
    @(negedge clk);
    rst2 = 0; pv2 = 1; idx2 = 0; pix2 = rgb(50, 0, 0); ordy2 = 0;
    @(negedge clk);
    rst2 = 1;
    for (int p = 0; p < 8; p++) begin
      chk("u2 img0 busy before last", busy2, 0);
      @(negedge clk);
    end
    chk("u2 img0 busy after last", busy2, 1);
    pix2 = rgb(255, 0, 0);
    n = 0;
    while (busy2 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("u2 busy cycles", n, 18);
    for (int p = 0; p < 8; p++) begin
      pv2 = 1; pix2 = rgb(40, 0, 0); idx2 = (p == 0);
      @(negedge clk);
      pv2 = 0; pix2 = rgb(200, 0, 0);
      if (p < 7) begin
        chk("u2 img1 busy during gaps", busy2, 0);
        @(negedge clk);
      end
    end
    chk("u2 img1 busy after last", busy2, 1);
    n = 0;
    while (!ov2 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("u2 out_valid timeout", ov2, 1);
    ordy2 = 1;
    chk("u2 entry0", {ci2, io2}, 3'b001);
    @(negedge clk);
    chk("u2 entry1", {ci2, io2}, 3'b000);
    @(negedge clk);
    chk("u2 done", done2, 1);

    @(negedge clk);
    rst3 = 0; pv3 = 1; pix3 = rgb(0, 7, 0);
    @(negedge clk);
    rst3 = 1;
    n = 0;
    while (!busy3 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("u3 pixels to busy", n, 16384);
    m = 0;
    while (busy3 && m < 40) begin
      m++;
      @(negedge clk);
    end
    chk("u3 busy cycles", m, 18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
